puf_resp_demux: RTL

- Response-side controller for the multi-PUF mux chains: the challenge muxes steer the race, and this block turns the arbiter output back into a response word.
- It fires the race launch, waits a fixed settle time, samples the single-bit arbiter output and repeats for majority voting.
- It demultiplexes each voted bit into its slot of a RESP_W-bit response word, then presents the word on a valid/ready handshake.
- It sits between the PUF arbiter and the response consumer (key extraction / host readout).

---
 rtl/puf_resp_demux.sv | 114 +++++++++++
 1 files changed

// File: rtl/puf_resp_demux.sv
// puf_resp_demux: fires PUF races, majority-votes VOTES samples per bit and assembles
// a RESP_W-bit response word on a valid/ready handshake. PUF_STABILITY_EN adds unstable_mask.
module puf_resp_demux #(
  parameter int RESP_W = 32,
  parameter int VOTES  = 5,
  parameter int SETTLE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      puf_launch,
  output logic [$clog2(RESP_W)-1:0] bit_idx,
  input  logic                      puf_resp,
  output logic                      busy,
  output logic [RESP_W-1:0]         resp_word,
  output logic                      resp_valid,
  input  logic                      resp_ready
`ifdef PUF_STABILITY_EN
  ,
  output logic [RESP_W-1:0]         unstable_mask
`endif
);
  localparam int BW = $clog2(RESP_W);
  localparam int VW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_W - 1);
  localparam logic [VW-1:0] VOTES_LAST  = VW'(VOTES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_SAMPLE, S_STORE, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [VW-1:0]   votes;
  logic [VW-1:0]   ones;
  logic [SW-1:0]   settle;

  function automatic logic majority(input logic [VW-1:0] cnt);
    return cnt > VW'(VOTES / 2);
  endfunction

  function automatic logic split_vote(input logic [VW-1:0] cnt);
    return (cnt != '0) && (cnt != VW'(VOTES));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (settle == SETTLE_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (votes < VOTES_LAST) ? S_LAUNCH : S_STORE;
      S_STORE:  state_nxt = (bit_idx == LAST_BIT) ? S_DONE : S_LAUNCH;
      S_DONE:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    puf_launch = (state == S_LAUNCH);
    busy       = (state != S_IDLE);
    resp_valid = (state == S_DONE);
  end

  // Counters and word assembly; votes/ones hold the running tally for the current bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= '0;
      votes     <= '0;
      ones      <= '0;
      settle    <= '0;
      resp_word <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          bit_idx <= '0;
          votes   <= '0;
          ones    <= '0;
          settle  <= '0;
        end
        S_WAIT:   settle <= (settle == SETTLE_LAST) ? '0 : settle + SW'(1);
        S_SAMPLE: begin
          ones  <= ones + VW'(puf_resp);
          votes <= votes + VW'(1);
        end
        S_STORE: begin
          resp_word[bit_idx] <= majority(ones);
          ones  <= '0;
          votes <= '0;
          if (bit_idx != LAST_BIT) bit_idx <= bit_idx + BW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PUF_STABILITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            unstable_mask <= '0;
    else if (state == S_IDLE && start)     unstable_mask <= '0;
    else if (state == S_STORE)             unstable_mask[bit_idx] <= split_vote(ones);
  end
`else
  logic unused_split;
  assign unused_split = split_vote(ones);
`endif

endmodule
